// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencer.
// Moore decode of registered state + op/funct; only beq's npc_sel follows alu_zero.
module mips_mc_ctrl #(
    parameter int unsigned MEM_LAT = 1  // legal range 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        alu_zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        npc_sel,
    output logic        isJump,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        ext_op,
    output logic        mem_we,
    output logic        mem2reg,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       npc_sel;
        logic       is_jump;
        logic       reg_we;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       mem_we;
        logic       mem2reg;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic [2:0] cnt_q;
    ctrl_t      c;
    logic [2:0] state_dbg;

    // Instruction fields other than op/funct belong to the datapath.
    logic unused_ins;
    assign unused_ins = ^ins[25:6];

    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_legal;
    assign is_addu  = (op_q == OP_RTYPE) && (funct_q == FN_ADDU);
    assign is_subu  = (op_q == OP_RTYPE) && (funct_q == FN_SUBU);
    assign is_ori   = (op_q == OP_ORI);
    assign is_lui   = (op_q == OP_LUI);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_j     = (op_q == OP_J);
    assign is_legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

    logic [1:0] alu_op_dec;
    logic       alu_src_dec, ext_op_dec;
    always_comb begin
        alu_op_dec = 2'b00;
        if (is_subu || is_beq) alu_op_dec = 2'b01;
        else if (is_ori)       alu_op_dec = 2'b10;
        else if (is_lui)       alu_op_dec = 2'b11;
    end
    assign alu_src_dec = is_ori | is_lui | is_lw | is_sw;
    assign ext_op_dec  = is_lw | is_sw | is_beq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q    <= ins[31:26];
                funct_q <= ins[5:0];
            end
            // Held at zero outside MEM, so every MEM entry starts counting from 0.
            cnt_q <= (state_q == S_MEM) ? cnt_q + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        c         = '0;
        state_d   = S_FETCH;
        state_dbg = state_q;
        case (state_q)
            S_FETCH: begin
                c.ir_we = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    c.pc_we   = 1'b1;
                    c.is_jump = 1'b1;
                end else if (!is_legal) begin
                    c.pc_we   = 1'b1;
                    c.illegal = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                c.alu_op  = alu_op_dec;
                c.alu_src = alu_src_dec;
                c.ext_op  = ext_op_dec;
                if (is_beq) begin
                    c.pc_we   = 1'b1;
                    c.npc_sel = alu_zero;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                c.alu_op  = alu_op_dec;
                c.alu_src = alu_src_dec;
                c.ext_op  = ext_op_dec;
                if (cnt_q != CNT_LAST) begin
                    state_d = S_MEM;
                end else if (is_sw) begin
                    c.mem_we = 1'b1;
                    c.pc_we  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                c.alu_op  = alu_op_dec;
                c.alu_src = alu_src_dec;
                c.ext_op  = ext_op_dec;
                c.reg_we  = 1'b1;
                c.pc_we   = 1'b1;
                c.mem2reg = is_lw;
                c.reg_dst = is_addu | is_subu;
            end
            default: begin
                state_d   = S_FETCH;
                state_dbg = 3'd0;
            end
        endcase
    end

    // Reset forces every output low in the same cycle, not just after the edge.
    assign pc_we   = rst ? 1'b0 : c.pc_we;
    assign ir_we   = rst ? 1'b0 : c.ir_we;
    assign npc_sel = rst ? 1'b0 : c.npc_sel;
    assign isJump  = rst ? 1'b0 : c.is_jump;
    assign reg_we  = rst ? 1'b0 : c.reg_we;
    assign reg_dst = rst ? 1'b0 : c.reg_dst;
    assign alu_src = rst ? 1'b0 : c.alu_src;
    assign alu_op  = rst ? 2'b00 : c.alu_op;
    assign ext_op  = rst ? 1'b0 : c.ext_op;
    assign mem_we  = rst ? 1'b0 : c.mem_we;
    assign mem2reg = rst ? 1'b0 : c.mem2reg;
    assign illegal = rst ? 1'b0 : c.illegal;
    assign state   = rst ? 3'd0 : state_dbg;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle vector table on a MEM_LAT=3
// instance plus a short lw/sw sequence on a MEM_LAT=1 instance.
module tb_mips_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_zero = 1'b0;
    logic [31:0] ins = 32'd0;

    logic       a_pc_we, a_ir_we, a_npc_sel, a_isJump, a_reg_we, a_reg_dst, a_alu_src;
    logic [1:0] a_alu_op;
    logic       a_ext_op, a_mem_we, a_mem2reg, a_illegal;
    logic [2:0] a_state;
    logic       b_pc_we, b_ir_we, b_npc_sel, b_isJump, b_reg_we, b_reg_dst, b_alu_src;
    logic [1:0] b_alu_op;
    logic       b_ext_op, b_mem_we, b_mem2reg, b_illegal;
    logic [2:0] b_state;

    int checks = 0;
    int failures = 0;

    mips_mc_ctrl #(.MEM_LAT(3)) dut (
        .clk(clk), .rst(rst), .ins(ins), .alu_zero(alu_zero),
        .pc_we(a_pc_we), .ir_we(a_ir_we), .npc_sel(a_npc_sel), .isJump(a_isJump),
        .reg_we(a_reg_we), .reg_dst(a_reg_dst), .alu_src(a_alu_src), .alu_op(a_alu_op),
        .ext_op(a_ext_op), .mem_we(a_mem_we), .mem2reg(a_mem2reg), .illegal(a_illegal),
        .state(a_state)
    );

    mips_mc_ctrl #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .ins(ins), .alu_zero(alu_zero),
        .pc_we(b_pc_we), .ir_we(b_ir_we), .npc_sel(b_npc_sel), .isJump(b_isJump),
        .reg_we(b_reg_we), .reg_dst(b_reg_dst), .alu_src(b_alu_src), .alu_op(b_alu_op),
        .ext_op(b_ext_op), .mem_we(b_mem_we), .mem2reg(b_mem2reg), .illegal(b_illegal),
        .state(b_state)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_SUBU = 32'h00221823;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_ORI  = 32'h34220005;
    localparam logic [31:0] I_LUI  = 32'h3C010012;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        az;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // {state, pc_we, ir_we, npc_sel, isJump, reg_we, reg_dst, alu_src, alu_op, ext_op, mem_we, mem2reg, illegal}
    function automatic logic [15:0] ex(input logic [2:0] st, input logic pc, ir, ns, jp, rw, rd, as,
                                       input logic [1:0] ao, input logic eo, mw, m2, il);
        return {st, pc, ir, ns, jp, rw, rd, as, ao, eo, mw, m2, il};
    endfunction

    task automatic add(input logic r, input logic [31:0] i, input logic az, input logic [15:0] e,
                       input string n);
        vec_t v;
        v.rst = r; v.ins = i; v.az = az; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", n, got, want);
        end
    endtask

    logic [15:0] act_a;
    assign act_a = {a_state, a_pc_we, a_ir_we, a_npc_sel, a_isJump, a_reg_we, a_reg_dst,
                    a_alu_src, a_alu_op, a_ext_op, a_mem_we, a_mem2reg, a_illegal};

    // {state, ir_we, pc_we, mem_we, reg_we, mem2reg}
    logic [7:0] act_b;
    assign act_b = {b_state, b_ir_we, b_pc_we, b_mem_we, b_reg_we, b_mem2reg};

    always @(negedge clk) begin
        #2;
        checks++;
        if (a_npc_sel && a_isJump) begin
            failures++;
            $display("FAIL npc_isjump_excl got=11 want=not both");
        end
    end

    initial begin
        // reset and addu
        add(1, 32'd0,  0, ex(0,0,0,0,0,0,0,0,2'b00,0,0,0,0), "rst.c0");
        add(1, I_ADDU, 0, ex(0,0,0,0,0,0,0,0,2'b00,0,0,0,0), "rst.c1");
        add(0, I_ADDU, 0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "addu.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "addu.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,0,2'b00,0,0,0,0), "addu.exec");
        add(0, I_JUNK, 0, ex(4,1,0,0,0,1,1,0,2'b00,0,0,0,0), "addu.wb");
        // beq taken / not taken
        add(0, I_BEQ,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "beq1.fetch");
        add(0, I_JUNK, 1, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "beq1.decode");
        add(0, I_JUNK, 1, ex(2,1,0,1,0,0,0,0,2'b01,1,0,0,0), "beq1.exec");
        add(0, I_BEQ,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "beq0.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "beq0.decode");
        add(0, I_JUNK, 0, ex(2,1,0,0,0,0,0,0,2'b01,1,0,0,0), "beq0.exec");
        // lw, 3 MEM cycles
        add(0, I_LW,   0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "lw.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "lw.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,1,2'b00,1,0,0,0), "lw.exec");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "lw.mem0");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "lw.mem1");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "lw.mem2");
        add(0, I_JUNK, 0, ex(4,1,0,0,0,1,0,1,2'b00,1,0,1,0), "lw.wb");
        // sw, mem_we on the last MEM cycle only
        add(0, I_SW,   0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "sw.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "sw.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,1,2'b00,1,0,0,0), "sw.exec");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "sw.mem0");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "sw.mem1");
        add(0, I_JUNK, 0, ex(3,1,0,0,0,0,0,1,2'b00,1,1,0,0), "sw.mem2");
        // j and illegal
        add(0, I_J,    0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "j.fetch");
        add(0, I_JUNK, 0, ex(1,1,0,0,1,0,0,0,2'b00,0,0,0,0), "j.decode");
        add(0, I_ILL,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "ill.fetch");
        add(0, I_JUNK, 0, ex(1,1,0,0,0,0,0,0,2'b00,0,0,0,1), "ill.decode");
        // ori / lui / subu / unsupported R-type
        add(0, I_ORI,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "ori.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "ori.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,1,2'b10,0,0,0,0), "ori.exec");
        add(0, I_JUNK, 0, ex(4,1,0,0,0,1,0,1,2'b10,0,0,0,0), "ori.wb");
        add(0, I_LUI,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "lui.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "lui.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,1,2'b11,0,0,0,0), "lui.exec");
        add(0, I_JUNK, 0, ex(4,1,0,0,0,1,0,1,2'b11,0,0,0,0), "lui.wb");
        add(0, I_SUBU, 0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "subu.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "subu.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,0,2'b01,0,0,0,0), "subu.exec");
        add(0, I_JUNK, 0, ex(4,1,0,0,0,1,1,0,2'b01,0,0,0,0), "subu.wb");
        add(0, I_ADD,  0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "add.fetch");
        add(0, I_JUNK, 0, ex(1,1,0,0,0,0,0,0,2'b00,0,0,0,1), "add.decode");
        // lw aborted by reset in its 2nd MEM cycle
        add(0, I_LW,   0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "abort.fetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "abort.decode");
        add(0, I_JUNK, 0, ex(2,0,0,0,0,0,0,1,2'b00,1,0,0,0), "abort.exec");
        add(0, I_JUNK, 0, ex(3,0,0,0,0,0,0,1,2'b00,1,0,0,0), "abort.mem0");
        add(1, I_JUNK, 0, ex(0,0,0,0,0,0,0,0,2'b00,0,0,0,0), "abort.rst");
        add(0, I_ADDU, 0, ex(0,0,1,0,0,0,0,0,2'b00,0,0,0,0), "abort.refetch");
        add(0, I_JUNK, 0, ex(1,0,0,0,0,0,0,0,2'b00,0,0,0,0), "abort.decode2");

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; ins = vecs[i].ins; alu_zero = vecs[i].az;
            #1;
            check(vecs[i].name, act_a, vecs[i].exp);
        end

        // MEM_LAT=1 instance: single MEM cycle for lw and sw
        begin
            logic [31:0] s_ins[12];
            logic        s_rst[12];
            logic [7:0]  s_exp[12];
            s_rst = '{1,1,0,0,0,0,0, 0,0,0,0, 0};
            s_ins = '{I_JUNK, I_JUNK, I_LW, I_JUNK, I_JUNK, I_JUNK, I_JUNK,
                      I_SW, I_JUNK, I_JUNK, I_JUNK, I_JUNK};
            s_exp = '{{3'd0,5'b00000}, {3'd0,5'b00000},
                      {3'd0,5'b10000}, {3'd1,5'b00000}, {3'd2,5'b00000}, {3'd3,5'b00000},
                      {3'd4,5'b01011},
                      {3'd0,5'b10000}, {3'd1,5'b00000}, {3'd2,5'b00000}, {3'd3,5'b01100},
                      {3'd0,5'b10000}};
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                rst = s_rst[k]; ins = s_ins[k]; alu_zero = 1'b0;
                #1;
                checks++;
                if (act_b !== s_exp[k]) begin
                    failures++;
                    $display("FAIL lat1.c%0d got=%b want=%b", k, act_b, s_exp[k]);
                end
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
